// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encodings and the default frame payload width.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } uart_arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] win_idx
);

  localparam int PTR_W = $clog2(NUM_REQ);

  always_comb begin : pick
    int   idx;
    logic found;
    any     = |req;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap: NUM_REQ need not be a power of two.
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[PTR_W'(idx)]) begin
        found   = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx serializer among NUM_REQ byte sources.
// Optional WAIT watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          en_tx,
  output logic [DATA_WIDTH-1:0]         data_tx,
  input  logic                          done_tx,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  uart_arb_state_e     state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_idx_q, win_idx_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                en_q, en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                busy_q, busy_d;

  logic                pick_any;
  logic [PTR_W-1:0]    pick_idx;
  logic [DATA_WIDTH-1:0] pick_data;
  logic [PTR_W-1:0]    ptr_next;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .any     (pick_any),
    .win_idx (pick_idx)
  );

  assign pick_data = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
  assign ptr_next  = (win_idx_q == PTR_W'(NUM_REQ-1)) ? '0 : win_idx_q + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 1);
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_idx_d = win_idx_q;
    grant_d   = '0;
    en_d      = 1'b0;
    data_d    = data_q;
    busy_d    = busy_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    terr_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (pick_any) begin
          grant_d   = NUM_REQ'(1) << pick_idx;
          en_d      = 1'b1;
          data_d    = pick_data;
          win_idx_d = pick_idx;
          busy_d    = 1'b1;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A done in the en_tx cycle belongs to the previous frame.
        if (done_tx && !en_q) begin
          ptr_d   = ptr_next;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
          terr_d  = 1'b1;
          ptr_d   = ptr_next;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      win_idx_q <= '0;
      grant_q   <= '0;
      en_q      <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_idx_q <= win_idx_d;
      grant_q   <= grant_d;
      en_q      <= en_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign grant   = grant_q;
  assign en_tx   = en_q;
  assign data_tx = data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with three requesters.
module tb_uart_tx_arbiter;

  localparam int NR = 3;
  localparam int DW = 7;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     grant;
  logic              en_tx;
  logic [DW-1:0]     data_tx;
  logic              done_tx = 1'b0;
  logic              busy;
  logic              timeout_err;
  logic [DW-1:0]     sl [NR];

  assign req_data = {sl[2], sl[1], sl[0]};

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .en_tx(en_tx), .data_tx(data_tx), .done_tx(done_tx),
    .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [NR-1:0] grant;
    logic [DW-1:0] data;
    int            win;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ptr   = 0;
  int   m_win   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [NR-1:0] r);
    for (int k = 0; k < NR; k++)
      if (r[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return 0;
  endfunction

  task automatic expect_grant(input logic [NR-1:0] r);
    exp_t e;
    e.win   = model_pick(r);
    e.grant = NR'(1) << e.win;
    e.data  = sl[e.win];
    sb_q.push_back(e);
  endtask

  task automatic wait_grant(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!en_tx && lat < 40);
    if (!en_tx) check({tag, " en_tx timeout"}, 32'(en_tx), 1);
    else if (sb_q.size() == 0) check({tag, " unexpected grant"}, 32'(grant), 0);
    else begin
      e = sb_q.pop_front();
      m_win = e.win;
      check({tag, " grant"}, 32'(grant), 32'(e.grant));
      check({tag, " data_tx"}, 32'(data_tx), 32'(e.data));
      check({tag, " busy rise"}, 32'(busy), 1);
      check({tag, " latency"}, lat, 1);
    end
  endtask

  task automatic hold_wait(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      tick();
      if (en_tx || grant != '0 || !busy || timeout_err) bad++;
    end
    check({tag, " wait hold"}, bad, 0);
  endtask

  task automatic finish_frame(input string tag);
    done_tx = 1'b1;
    tick();
    done_tx = 1'b0;
    check({tag, " busy fall"}, 32'(busy), 0);
    m_ptr = (m_win + 1) % NR;
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NR; i++) sl[i] = '0;
    #12;
    check("rst grant", 32'(grant), 0);
    check("rst en_tx", 32'(en_tx), 0);
    check("rst data_tx", 32'(data_tx), 0);
    check("rst busy", 32'(busy), 0);
    check("rst timeout_err", 32'(timeout_err), 0);
    rst_n = 1'b1;
    tick();

    // Single requester
    sl[0] = 7'h41;
    req = 3'b001;
    expect_grant(req);
    wait_grant("single");
    req = '0;
    tick();
    check("single en pulse", 32'(en_tx), 0);
    check("single grant pulse", 32'(grant), 0);
    hold_wait("single", 11);
    check("single data held", 32'(data_tx), 32'h41);
    finish_frame("single");

    // Spurious done in IDLE
    done_tx = 1'b1;
    tick();
    done_tx = 1'b0;
    check("idle done busy", 32'(busy), 0);
    check("idle done en_tx", 32'(en_tx), 0);
    tick();

    // done coincident with en_tx is ignored
    sl[1] = 7'h33;
    req = 3'b010;
    expect_grant(req);
    wait_grant("coinc");
    req = '0;
    done_tx = 1'b1;
    tick();
    done_tx = 1'b0;
    check("coinc still busy", 32'(busy), 1);
    hold_wait("coinc", 5);
    finish_frame("coinc");

    // Wrap with three requesters: ptr now 2
    sl[0] = 7'h0A;
    sl[2] = 7'h5C;
    req = 3'b101;
    expect_grant(req);
    wait_grant("wrap0");
    check("wrap0 slot2", 32'(grant), 32'b100);
    hold_wait("wrap0", 3);
    finish_frame("wrap0");
    expect_grant(req);
    wait_grant("wrap1");
    check("wrap1 slot0", 32'(grant), 32'b001);
    req = '0;
    hold_wait("wrap1", 3);
    finish_frame("wrap1");

    // Fairness under sustained requests
    sl[0] = 7'h11;
    sl[1] = 7'h22;
    req = 3'b011;
    for (int f = 0; f < 4; f++) begin
      expect_grant(req);
      wait_grant("fair");
      if (f == 3) req = '0;
      hold_wait("fair", 9);
      finish_frame("fair");
    end

    // Randomised traffic
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NR; i++) sl[i] = DW'($urandom);
      req = NR'($urandom_range(1, 7));
      expect_grant(req);
      wait_grant("rand");
      req = '0;
      hold_wait("rand", $urandom_range(1, 6));
      finish_frame("rand");
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Reset mid-frame
    sl[0] = 7'h55;
    req = 3'b001;
    expect_grant(req);
    wait_grant("midrst");
    req = '0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst grant", 32'(grant), 0);
    check("midrst en_tx", 32'(en_tx), 0);
    check("midrst data_tx", 32'(data_tx), 0);
    check("midrst busy", 32'(busy), 0);
    check("midrst timeout_err", 32'(timeout_err), 0);
    m_ptr = 0;
    tick();
    rst_n = 1'b1;
    tick();
    sl[1] = 7'h66;
    req = 3'b010;
    expect_grant(req);
    wait_grant("postrst");
    check("postrst slot1", 32'(grant), 32'b010);
    req = '0;
    hold_wait("postrst", 3);
    finish_frame("postrst");

`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int bad;
      sl[0] = 7'h01;
      sl[1] = 7'h02;
      req = 3'b011;
      expect_grant(req);
      wait_grant("wd");
      bad = 0;
      repeat (TO - 1) begin
        tick();
        if (timeout_err || !busy) bad++;
      end
      check("wd early", bad, 0);
      tick();
      check("wd timeout_err", 32'(timeout_err), 1);
      check("wd busy fall", 32'(busy), 0);
      m_ptr = (m_win + 1) % NR;
      expect_grant(req);
      wait_grant("wd next");
      check("wd pulse width", 32'(timeout_err), 0);
      req = '0;
      hold_wait("wd next", 3);
      finish_frame("wd next");
    end
`else
    begin
      int bad;
      sl[0] = 7'h01;
      req = 3'b001;
      expect_grant(req);
      wait_grant("nowd");
      req = '0;
      bad = 0;
      repeat (2 * TO) begin
        tick();
        if (timeout_err || !busy) bad++;
      end
      check("nowd waits", bad, 0);
      finish_frame("nowd");
    end
`endif

    tick();
    check("sb empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
